// File: rtl/traffic_light_monitor_if.sv
// Light buses and error-clear strobe shared between the traffic light controller and its monitor.
// Encoding per light: one-hot, bit2=red, bit1=yellow, bit0=green.
interface traffic_light_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic       clr_err;

  modport master (output light_M1, light_M2, light_MT, light_S, clr_err);
  modport slave  (input  light_M1, light_M2, light_MT, light_S, clr_err);
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the four traffic light buses: sticky error flags,
// a saturating violation counter and a count of completed side-road cycles.
module traffic_light_monitor #(
  parameter int YEL_MIN   = 3,
  parameter int STUCK_MAX = 64,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_monitor_if.slave i_bus,
  output logic                  err_encoding,
  output logic                  err_conflict,
  output logic                  err_sequence,
  output logic                  err_yellow_short,
  output logic                  err_stuck,
  output logic                  err_any,
  output logic [CNT_W-1:0]      violation_count,
  output logic [CNT_W-1:0]      s_cycle_count
);
  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b001;
  localparam int DW = (STUCK_MAX > 2) ? $clog2(STUCK_MAX) : 1;
  localparam int YW = $clog2(YEL_MIN + 1);

  // Light index: 0=M1, 1=M2, 2=MT, 3=S
  logic [2:0] w_light [4];
  logic [2:0] w_prev  [4];
  logic [3:0] w_valid;
  logic [3:0] w_nonred;
  logic [3:0] w_seq_err;
  logic [3:0] w_ysh_err;
  logic [3:0] w_stuck_err;
  logic       r_prev_valid;

  assign w_light[0] = i_bus.light_M1;
  assign w_light[1] = i_bus.light_M2;
  assign w_light[2] = i_bus.light_MT;
  assign w_light[3] = i_bus.light_S;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_light
      logic [2:0]    r_prev;
      logic [DW-1:0] r_dwell;
      logic [DW-1:0] w_dwell_next;
      logic [YW-1:0] r_ycnt;
      logic [YW-1:0] w_ycnt_next;
      logic          w_same;
      logic          w_legal;

      assign w_valid[gi]  = (w_light[gi] == C_RED) || (w_light[gi] == C_YEL) ||
                            (w_light[gi] == C_GRN);
      assign w_nonred[gi] = (w_light[gi] != C_RED);
      assign w_same       = (w_light[gi] == r_prev);
      assign w_legal      = w_same ||
                            ((r_prev == C_GRN) && (w_light[gi] == C_YEL)) ||
                            ((r_prev == C_YEL) && (w_light[gi] == C_RED)) ||
                            ((r_prev == C_RED) && (w_light[gi] == C_GRN));
      assign w_prev[gi]   = r_prev;

      assign w_seq_err[gi]   = w_valid[gi] && r_prev_valid && !w_legal;
      assign w_ysh_err[gi]   = w_valid[gi] && (r_prev == C_YEL) && (w_light[gi] != C_YEL) &&
                               (r_ycnt < YW'(YEL_MIN));
      // Fires once, on the sample that brings the dwell count to STUCK_MAX-1
      assign w_stuck_err[gi] = w_valid[gi] && r_prev_valid && w_same &&
                               (r_dwell == DW'(STUCK_MAX - 2));

      always_comb begin
        w_dwell_next = r_dwell;
        w_ycnt_next  = r_ycnt;
        if (w_valid[gi]) begin
          if (!(r_prev_valid && w_same))
            w_dwell_next = '0;
          else if (r_dwell != DW'(STUCK_MAX - 1))
            w_dwell_next = r_dwell + 1'b1;

          if (w_light[gi] != C_YEL)
            w_ycnt_next = '0;
          else if (r_prev != C_YEL)
            w_ycnt_next = YW'(1);
          else if (r_ycnt < YW'(YEL_MIN))
            w_ycnt_next = r_ycnt + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_prev  <= C_RED;
          r_dwell <= '0;
          r_ycnt  <= '0;
        end else begin
          if (w_valid[gi])
            r_prev <= w_light[gi];
          r_dwell <= w_dwell_next;
          r_ycnt  <= w_ycnt_next;
        end
      end
    end
  endgenerate

  logic             w_conflict;
  logic [4:0]       w_new;
  logic             w_viol;
  logic             w_s_done;
  logic [4:0]       r_err;
  logic [4:0]       w_err_next;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] w_vcnt_next;
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] w_scnt_next;
  logic             r_s_ok;
  logic             w_s_ok_next;

  assign w_conflict = (w_nonred[3] && (|w_nonred[2:0])) || (w_nonred[2] && w_nonred[1]);
  assign w_new      = {~&w_valid, w_conflict, |w_seq_err, |w_ysh_err, |w_stuck_err};
  assign w_viol     = |w_new;
  assign w_s_done   = w_valid[3] && (w_prev[3] == C_YEL) && (w_light[3] == C_RED) &&
                      r_s_ok && !w_ysh_err[3];

  always_comb begin
    w_err_next  = (i_bus.clr_err ? 5'b0 : r_err) | w_new;
    w_vcnt_next = i_bus.clr_err ? '0 : r_vcnt;
    if (w_viol && (w_vcnt_next != '1))
      w_vcnt_next = w_vcnt_next + 1'b1;

    w_scnt_next = r_scnt;
    if (w_s_done)
      w_scnt_next = r_scnt + 1'b1;

    // r_s_ok: the current S phase entered green legally and has stayed legal since
    w_s_ok_next = r_s_ok;
    if (!w_valid[3] || w_seq_err[3])
      w_s_ok_next = 1'b0;
    else if ((w_prev[3] == C_RED) && (w_light[3] == C_GRN))
      w_s_ok_next = 1'b1;
    else if ((w_prev[3] == C_YEL) && (w_light[3] != C_YEL))
      w_s_ok_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err        <= '0;
      r_vcnt       <= '0;
      r_scnt       <= '0;
      r_s_ok       <= 1'b0;
      r_prev_valid <= 1'b0;
    end else begin
      r_err        <= w_err_next;
      r_vcnt       <= w_vcnt_next;
      r_scnt       <= w_scnt_next;
      r_s_ok       <= w_s_ok_next;
      r_prev_valid <= 1'b1;
    end
  end

  assign {err_encoding, err_conflict, err_sequence, err_yellow_short, err_stuck} = r_err;
  assign err_any         = |r_err;
  assign violation_count = r_vcnt;
  assign s_cycle_count   = r_scnt;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed table-driven bench for traffic_light_monitor plus a hand-written
// asynchronous-reset-mid-yellow sequence.
module tb_traffic_light_monitor;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_ENC  = 5'b10000;
  localparam logic [4:0] E_CON  = 5'b01000;
  localparam logic [4:0] E_SEQ  = 5'b00100;
  localparam logic [4:0] E_YSH  = 5'b00010;
  localparam logic [4:0] E_STK  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_encoding, err_conflict, err_sequence, err_yellow_short, err_stuck, err_any;
  logic [7:0] violation_count, s_cycle_count;
  logic [4:0] err_vec;

  traffic_light_monitor_if bus_if ();

  traffic_light_monitor #(.YEL_MIN(3), .STUCK_MAX(64), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_bus            (bus_if),
    .err_encoding     (err_encoding),
    .err_conflict     (err_conflict),
    .err_sequence     (err_sequence),
    .err_yellow_short (err_yellow_short),
    .err_stuck        (err_stuck),
    .err_any          (err_any),
    .violation_count  (violation_count),
    .s_cycle_count    (s_cycle_count)
  );

  always #5 clk = ~clk;

  assign err_vec = {err_encoding, err_conflict, err_sequence, err_yellow_short, err_stuck};

  typedef struct {
    logic       rst;
    int         n;
    logic [2:0] m1, m2, mt, s;
    logic       clr;
    logic [4:0] e_err;
    logic [7:0] e_vc;
    logic [7:0] e_sc;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   row_id   = 0;

  function automatic vec_t mk(input logic r, input int n, input logic [2:0] m1, input logic [2:0] m2,
                              input logic [2:0] mt, input logic [2:0] s, input logic clr,
                              input logic [4:0] e, input logic [7:0] vc, input logic [7:0] sc);
    vec_t v;
    v.rst = r; v.n = n; v.m1 = m1; v.m2 = m2; v.mt = mt; v.s = s; v.clr = clr;
    v.e_err = e; v.e_vc = vc; v.e_sc = sc;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] e, input logic [7:0] vc, input logic [7:0] sc);
    chk({tag, " err_flags"}, 32'(err_vec), 32'(e));
    chk({tag, " err_any"}, 32'(err_any), 32'(|e));
    chk({tag, " violation_count"}, 32'(violation_count), 32'(vc));
    chk({tag, " s_cycle_count"}, 32'(s_cycle_count), 32'(sc));
  endtask

  // Entered and left at posedge+1
  task automatic apply(input vec_t v);
    bus_if.light_M1 = v.m1;
    bus_if.light_M2 = v.m2;
    bus_if.light_MT = v.mt;
    bus_if.light_S  = v.s;
    bus_if.clr_err  = v.clr;
    if (v.rst) begin
      rst = 1'b1;
      #2;
      rst = 1'b0;
    end
    repeat (v.n) @(posedge clk);
    #1;
    $display("row %0d: rst=%0b n=%0d M1=%b M2=%b MT=%b S=%b clr=%0b -> err=%b vc=%0d sc=%0d",
             row_id, v.rst, v.n, v.m1, v.m2, v.mt, v.s, v.clr, err_vec, violation_count, s_cycle_count);
    check_outs($sformatf("row%0d", row_id), v.e_err, v.e_vc, v.e_sc);
    row_id++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Legal full cycle
    tbl.push_back(mk(1, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 10, G, G, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 3,  Y, Y, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 3,  R, R, G, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 3,  R, R, Y, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 5,  R, R, R, G, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 3,  R, R, R, Y, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 2,  R, R, R, R, 0, E_NONE, 0, 1));
    tbl.push_back(mk(0, 1,  R, R, R, R, 1, E_NONE, 0, 1));
    // Conflict, then clear in the same cycle as a conflict
    tbl.push_back(mk(1, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  G, R, R, G, 0, E_CON,  1, 0));
    tbl.push_back(mk(0, 1,  G, R, R, G, 0, E_CON,  2, 0));
    tbl.push_back(mk(0, 1,  G, R, R, G, 1, E_CON,  1, 0));
    // MT vs M2 conflict
    tbl.push_back(mk(1, 1,  R, G, G, R, 0, E_CON,  1, 0));
    // Sequence error, then clear
    tbl.push_back(mk(1, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 2,  R, G, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 0, E_SEQ,  1, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 1, E_NONE, 0, 0));
    // Encoding error leaves the previous colour intact
    tbl.push_back(mk(1, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 2,  R, R, G, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  R, R, 3'b011, R, 0, E_ENC, 1, 0));
    tbl.push_back(mk(0, 1,  R, R, Y, R, 0, E_ENC,  1, 0));
    tbl.push_back(mk(0, 2,  R, R, Y, R, 0, E_ENC,  1, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 0, E_ENC,  1, 0));
    tbl.push_back(mk(0, 1,  R, R, 3'b000, R, 0, E_ENC, 2, 0));
    // Short yellow, then exactly YEL_MIN yellow
    tbl.push_back(mk(1, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 2,  G, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 2,  Y, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 0, E_YSH,  1, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 1, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  G, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 3,  Y, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  R, R, R, R, 0, E_NONE, 0, 0));
    // Stuck: every light fires together on sample 64
    tbl.push_back(mk(1, 63, G, R, R, R, 0, E_NONE, 0, 0));
    tbl.push_back(mk(0, 1,  G, R, R, R, 0, E_STK,  1, 0));
    // Violation counter saturation
    tbl.push_back(mk(1, 300, G, R, R, G, 0, E_CON | E_STK, 8'hFF, 0));

    bus_if.light_M1 = G;
    bus_if.light_M2 = R;
    bus_if.light_MT = R;
    bus_if.light_S  = G;
    bus_if.clr_err  = 1'b0;
    rst = 1'b1;
    #1;
    check_outs("reset_async", E_NONE, 0, 0);
    @(posedge clk);
    #1;
    check_outs("reset_held", E_NONE, 0, 0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset in the middle of a yellow phase
    apply(mk(1, 2, G, R, R, R, 0, E_NONE, 0, 0));
    apply(mk(0, 1, Y, R, 3'b011, R, 0, E_ENC, 1, 0));
    rst = 1'b1;
    #1;
    $display("async reset mid-yellow: err=%b vc=%0d sc=%0d", err_vec, violation_count, s_cycle_count);
    check_outs("rst_mid_yellow", E_NONE, 0, 0);
    #1;
    rst = 1'b0;
    apply(mk(0, 3, Y, R, R, R, 0, E_NONE, 0, 0));
    apply(mk(0, 1, R, R, R, R, 0, E_NONE, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the four light buses driven by the traffic light controller (M1, M2, MT, S).
- Samples every clock and tracks each light's state and dwell time.
- Raises sticky error flags for illegal encoding, conflicting greens, illegal colour sequences, short yellow phases and stuck lights; counts violations and completed S-road cycles.
- Instantiated beside the controller in simulation and optionally in silicon as a safety monitor.

Parameters:
- YEL_MIN, 3, minimum consecutive cycles a light must stay yellow.
- STUCK_MAX, 64, cycles a light may hold one colour before err_stuck fires.
- CNT_W, 8, width of violation_count and s_cycle_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- light_M1  input  3  main road 1 light; one-hot, bit2=red, bit1=yellow, bit0=green.
- light_M2  input  3  main road 2 light, same encoding.
- light_MT  input  3  main-road turn light, same encoding.
- light_S  input  3  side road light, same encoding.
- clr_err  input  1  synchronous clear of all error flags and violation_count.
- err_encoding  output  1  sticky; a light was not one-hot.
- err_conflict  output  1  sticky; conflicting non-red lights.
- err_sequence  output  1  sticky; illegal colour transition.
- err_yellow_short  output  1  sticky; yellow shorter than YEL_MIN.
- err_stuck  output  1  sticky; a light held one colour for STUCK_MAX cycles.
- err_any  output  1  OR of the five error flags, combinational from registers.
- violation_count  output  CNT_W  number of cycles with at least one new violation; saturates at all-ones.
- s_cycle_count  output  CNT_W  completed S cycles (green→yellow→red); wraps.

Behaviour:
- Reset (async, rst=1): all err_* = 0, both counts = 0, prev_valid = 0, dwell counters = 0, previous-light registers = 3'b100.
- Each rising edge samples all four lights. Flags and counts update on that edge, so they are visible 1 cycle after the offending sample.
- Encoding: a value that is not 100, 010 or 001 sets err_encoding. That light's sequence, yellow and stuck checks are skipped for the sample, and its previous register is not updated.
- Conflict rules:
  - S non-red while any of M1, M2, MT is non-red.
  - MT non-red while M2 is non-red.
  - Either case sets err_conflict.
- Sequence: per light, only these transitions are legal: green→yellow, yellow→red, red→green, or unchanged. Any other transition sets err_sequence. The check applies only when prev_valid=1; prev_valid sets after the first post-reset sample.
- Yellow dwell:
  - A per-light counter counts consecutive yellow samples.
  - On leaving yellow with count < YEL_MIN, err_yellow_short sets.
  - Leaving yellow by reset is not a violation.
- Stuck:
  - A per-light dwell counter increments while the colour is unchanged and clears on change.
  - When it reaches STUCK_MAX−1, err_stuck sets.
  - The counter saturates and does not wrap.
- violation_count increments by exactly 1 in any cycle where one or more checks fire, even if the flag was already set. It saturates at 2^CNT_W−1.
- s_cycle_count increments on the S yellow→red transition when that S phase's green and yellow were legal.
- clr_err: clears the flags and violation_count on the next edge. Dwell counters, prev_valid and s_cycle_count are unaffected. A violation in the same cycle wins, so the flag stays 1 and the count becomes 1.
- Reset asserted mid-phase: the state clears immediately. The monitor re-learns from the next sample with no false sequence error.

Test Plan:
- Legal cycle: M1/M2 green 10 cycles, yellow 3, red; then MT green/yellow 3/red; then S green 5, yellow 3, red → all err_* = 0, s_cycle_count = 1, violation_count = 0.
- Conflict: drive S=001 and M1=001 for 2 cycles → err_conflict=1 one cycle after the first sample, violation_count=2, err_any=1.
- Sequence and encoding: M2 goes 001→100 directly → err_sequence=1. Separately drive light_MT=3'b011 → err_encoding=1, err_sequence stays at its prior value.
- Short yellow, YEL_MIN=3: M1 yellow for 2 cycles then red → err_yellow_short=1. Yellow for exactly 3 cycles → no flag.
- Stuck, STUCK_MAX=64: hold S=100 and M1=001 unchanged for 64 cycles → err_stuck=1 on the edge after sample 64, not before.
- Clear and reset:
  - After flags are set, pulse clr_err → all flags 0 and violation_count 0 next cycle.
  - Pulse clr_err with a conflict in the same cycle → err_conflict=1, violation_count=1.
  - Assert rst mid-yellow → outputs 0 asynchronously, and no error on resume.
